// File: rtl/skipper_cds_accumulator_if.sv
// Result channel of the CDS accumulator: one signed sum per pixel, tagged with its
// index in the cluster, transferred over a valid/ready handshake.
`timescale 1ns/1ps
interface skipper_cds_accumulator_if #(
  parameter int ACC_WIDTH = 32
);
  logic                        out_valid;
  logic                        out_ready;
  logic signed [ACC_WIDTH-1:0] out_sum;
  logic        [3:0]           out_pixel;
  logic                        out_sat;

  modport master (output out_valid, out_sum, out_pixel, out_sat, input out_ready);
  modport slave  (input out_valid, out_sum, out_pixel, out_sat, output out_ready);
endinterface

// File: rtl/skipper_cds_accumulator.sv
// Correlated double sampling on SPROCKET phi1/phi2 strobe pairs, summing the
// signal-minus-baseline differences of skip_samples pairs into one result per pixel.
`timescale 1ns/1ps
module skipper_cds_accumulator #(
  parameter int ADC_WIDTH          = 12,
  parameter int ACC_WIDTH          = 32,
  parameter int PIXEL_CLUSTER_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 integration,
  input  logic [15:0]          skip_samples,
  input  logic                 phi1,
  input  logic                 phi2,
  input  logic [ADC_WIDTH-1:0] adc_data,
  input  logic                 err_clr,
  output logic                 err_order,
  output logic                 err_drop,
  skipper_cds_accumulator_if.master res
);

  typedef enum logic [1:0] {IDLE, WAIT_SIG, WAIT_BASE, OUT} state_e;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX    = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN    = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [3:0]           LAST_PIXEL = 4'(PIXEL_CLUSTER_SIZE - 1);

  state_e               state_q, state_d;
  logic                 phi1Prev_q, phi2Prev_q, integPrev_q;
  logic [ADC_WIDTH-1:0] base_q, base_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 sat_q, sat_d;
  logic [15:0]          skipLeft_q, skipLeft_d;
  logic [3:0]           pixelIdx_q, pixelIdx_d;
  logic                 clrPending_q, clrPending_d;
  logic                 errOrder_q, errOrder_d;
  logic                 errDrop_q, errDrop_d;

  logic                    risePhi1, risePhi2, riseInteg, bothRise, accepted;
  logic                    errOrderSet, errDropSet;
  logic signed [ADC_WIDTH:0] diff;
  logic [ACC_WIDTH:0]      sumWide;
  logic                    sumOvf;
  logic [ACC_WIDTH-1:0]    sumSat;
  logic [3:0]              pixelNext;

  assign risePhi1  = phi1 & ~phi1Prev_q;
  assign risePhi2  = phi2 & ~phi2Prev_q;
  assign riseInteg = integration & ~integPrev_q;
  assign bothRise  = risePhi1 & risePhi2;
  assign accepted  = (state_q == OUT) & res.out_ready;

  // One guard bit above the accumulator exposes overflow before clamping.
  assign diff    = $signed({1'b0, adc_data}) - $signed({1'b0, base_q});
  assign sumWide = {acc_q[ACC_WIDTH-1], acc_q}
                 + {{(ACC_WIDTH-ADC_WIDTH){diff[ADC_WIDTH]}}, diff};
  assign sumOvf  = sumWide[ACC_WIDTH] ^ sumWide[ACC_WIDTH-1];
  assign sumSat  = !sumOvf ? sumWide[ACC_WIDTH-1:0]
                           : (sumWide[ACC_WIDTH] ? ACC_MIN : ACC_MAX);

  assign pixelNext = (pixelIdx_q == LAST_PIXEL) ? 4'd0 : pixelIdx_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    acc_d        = acc_q;
    sat_d        = sat_q;
    skipLeft_d   = skipLeft_q;
    pixelIdx_d   = pixelIdx_q;
    clrPending_d = clrPending_q;
    errOrderSet  = 1'b0;
    errDropSet   = 1'b0;

    // A new cluster aborts a partial pixel, but a finished result is still delivered.
    if (riseInteg && state_q != OUT) begin
      state_d    = IDLE;
      pixelIdx_d = 4'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bothRise || risePhi2) begin
            errOrderSet = 1'b1;
          end else if (risePhi1) begin
            base_d     = adc_data;
            skipLeft_d = (skip_samples == 16'd0) ? 16'd1 : skip_samples;
            acc_d      = '0;
            sat_d      = 1'b0;
            state_d    = WAIT_SIG;
          end
        end
        WAIT_SIG: begin
          if (bothRise) begin
            errOrderSet = 1'b1;
          end else if (risePhi2) begin
            acc_d = sumSat;
            sat_d = sat_q | sumOvf;
            if (skipLeft_q == 16'd1) begin
              state_d = OUT;
            end else begin
              skipLeft_d = skipLeft_q - 16'd1;
              state_d    = WAIT_BASE;
            end
          end else if (risePhi1) begin
            errOrderSet = 1'b1;
            base_d      = adc_data;
          end
        end
        WAIT_BASE: begin
          if (bothRise || risePhi2) begin
            errOrderSet = 1'b1;
          end else if (risePhi1) begin
            base_d  = adc_data;
            state_d = WAIT_SIG;
          end
        end
        OUT: begin
          errDropSet = risePhi1 | risePhi2;
          if (riseInteg) clrPending_d = 1'b1;
          if (accepted) begin
            state_d      = IDLE;
            pixelIdx_d   = (clrPending_q | riseInteg) ? 4'd0 : pixelNext;
            clrPending_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    errOrder_d = errOrderSet | (errOrder_q & ~err_clr);
    errDrop_d  = errDropSet  | (errDrop_q  & ~err_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      phi1Prev_q   <= 1'b0;
      phi2Prev_q   <= 1'b0;
      integPrev_q  <= 1'b0;
      base_q       <= '0;
      acc_q        <= '0;
      sat_q        <= 1'b0;
      skipLeft_q   <= '0;
      pixelIdx_q   <= '0;
      clrPending_q <= 1'b0;
      errOrder_q   <= 1'b0;
      errDrop_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      phi1Prev_q   <= phi1;
      phi2Prev_q   <= phi2;
      integPrev_q  <= integration;
      base_q       <= base_d;
      acc_q        <= acc_d;
      sat_q        <= sat_d;
      skipLeft_q   <= skipLeft_d;
      pixelIdx_q   <= pixelIdx_d;
      clrPending_q <= clrPending_d;
      errOrder_q   <= errOrder_d;
      errDrop_q    <= errDrop_d;
    end
  end

  assign res.out_valid = (state_q == OUT);
  assign res.out_sum   = acc_q;
  assign res.out_pixel = pixelIdx_q;
  assign res.out_sat   = sat_q;
  assign err_order     = errOrder_q;
  assign err_drop      = errDrop_q;

endmodule

// File: tb/tb_skipper_cds_accumulator.sv
// Bench for skipper_cds_accumulator: table of CDS pixels plus hand-written corner sequences,
// with a result scoreboard; a 13-bit accumulator copy shares the stimulus for saturation.
`timescale 1ns/1ps
module tb_skipper_cds_accumulator;

  typedef struct packed {
    logic [15:0]       skip;
    logic [2:0]        n;
    logic [3:0][11:0]  base;
    logic [3:0][11:0]  sig;
    logic signed [31:0] expSum;
  } vector_t;

  typedef struct {
    logic signed [31:0] sum;
    logic [3:0]         pixel;
    logic               sat;
  } result_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        integration;
  logic [15:0] skipSamples;
  logic        phi1, phi2;
  logic [11:0] adcData;
  logic        errClr;
  logic        outReady;
  logic        errOrder, errDrop, satErrOrder, satErrDrop;

  int      total = 0;
  int      bad   = 0;
  result_t expQ[$];
  result_t monExp;
  logic [3:0] expPixel;
  logic [3:0] heldPixel;
  vector_t vecs[6];

  always #5 clk = ~clk;

  skipper_cds_accumulator_if #(.ACC_WIDTH(32)) resIf();
  skipper_cds_accumulator_if #(.ACC_WIDTH(13)) satIf();
  assign resIf.out_ready = outReady;
  assign satIf.out_ready = outReady;

  skipper_cds_accumulator #(.ADC_WIDTH(12), .ACC_WIDTH(32), .PIXEL_CLUSTER_SIZE(16)) dut (
    .clk(clk), .reset(reset), .integration(integration), .skip_samples(skipSamples),
    .phi1(phi1), .phi2(phi2), .adc_data(adcData), .err_clr(errClr),
    .err_order(errOrder), .err_drop(errDrop), .res(resIf)
  );

  skipper_cds_accumulator #(.ADC_WIDTH(12), .ACC_WIDTH(13), .PIXEL_CLUSTER_SIZE(16)) satDut (
    .clk(clk), .reset(reset), .integration(integration), .skip_samples(skipSamples),
    .phi1(phi1), .phi2(phi2), .adc_data(adcData), .err_clr(errClr),
    .err_order(satErrOrder), .err_drop(satErrDrop), .res(satIf)
  );

  task automatic checkOutput(input string name, input logic signed [63:0] act,
                             input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic strobe(input int which, input int val);
    tick();
    adcData = 12'(val);
    if (which == 1) phi1 = 1'b1;
    else            phi2 = 1'b1;
    tick();
    phi1 = 1'b0;
    phi2 = 1'b0;
  endtask

  task automatic pair(input int b, input int s);
    strobe(1, b);
    strobe(2, s);
  endtask

  task automatic pushExp(input int sum, input logic sat);
    result_t r;
    r.sum   = 32'(sum);
    r.pixel = expPixel;
    r.sat   = sat;
    expQ.push_back(r);
    expPixel = 4'((int'(expPixel) + 1) % 16);
  endtask

  task automatic pulseErrClr();
    tick();
    errClr = 1'b1;
    tick();
    errClr = 1'b0;
  endtask

  task automatic riseIntegration();
    tick();
    integration = 1'b1;
    tick();
    integration = 1'b0;
  endtask

  task automatic applyStimulus(input vector_t v);
    skipSamples = v.skip;
    pushExp(int'(v.expSum), 1'b0);
    for (int k = 0; k < int'(v.n); k++) pair(int'(v.base[k]), int'(v.sig[k]));
  endtask

  function automatic vector_t mkVec(input int skip, input int n,
                                    input int b0, input int s0, input int b1, input int s1,
                                    input int b2, input int s2, input int b3, input int s3,
                                    input int expSum);
    vector_t v;
    v.skip    = 16'(skip);
    v.n       = 3'(n);
    v.base[0] = 12'(b0); v.sig[0] = 12'(s0);
    v.base[1] = 12'(b1); v.sig[1] = 12'(s1);
    v.base[2] = 12'(b2); v.sig[2] = 12'(s2);
    v.base[3] = 12'(b3); v.sig[3] = 12'(s3);
    v.expSum  = 32'(expSum);
    return v;
  endfunction

  // Scoreboard: every accepted result must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && resIf.out_valid && outReady) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected result: got sum %0d pixel %0d, expected none",
                 resIf.out_sum, resIf.out_pixel);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("result sum", resIf.out_sum, monExp.sum);
        checkOutput("result pixel", resIf.out_pixel, monExp.pixel);
        checkOutput("result sat", resIf.out_sat, monExp.sat);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = mkVec(1, 1, 100, 160, 0, 0, 0, 0, 0, 0, 60);
    vecs[1] = mkVec(4, 4, 100, 90, 100, 95, 200, 180, 0, 4095, 4060);
    vecs[2] = mkVec(0, 1, 500, 20, 0, 0, 0, 0, 0, 0, -480);
    vecs[3] = mkVec(2, 2, 4095, 0, 4095, 0, 0, 0, 0, 0, -8190);
    vecs[4] = mkVec(3, 3, 10, 10, 7, 8, 1000, 999, 0, 0, 0);
    vecs[5] = mkVec(2, 2, 0, 4095, 0, 4095, 0, 0, 0, 0, 8190);

    reset = 1'b1; integration = 1'b0; skipSamples = 16'd1; phi1 = 1'b0; phi2 = 1'b0;
    adcData = '0; errClr = 1'b0; outReady = 1'b1; expPixel = 4'd0;
    tick();
    tick();
    checkOutput("reset out_valid", resIf.out_valid, 0);
    checkOutput("reset out_sum", resIf.out_sum, 0);
    checkOutput("reset out_pixel", resIf.out_pixel, 0);
    checkOutput("reset out_sat", resIf.out_sat, 0);
    checkOutput("reset err_order", errOrder, 0);
    checkOutput("reset err_drop", errDrop, 0);
    reset = 1'b0;
    tick();

    // Table: one pixel per record; valid must be up one cycle after the last phi2 rise.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vector %0d latency", i), resIf.out_valid, 1);
    end
    tick();
    checkOutput("table err_order", errOrder, 0);
    checkOutput("table err_drop", errDrop, 0);

    // Back-pressure: second pair arrives while pixel 6 is pending.
    outReady = 1'b0;
    skipSamples = 16'd1;
    pushExp(30, 1'b0);
    pair(100, 130);
    checkOutput("stall valid", resIf.out_valid, 1);
    checkOutput("stall sum", resIf.out_sum, 30);
    pair(5, 9);
    checkOutput("drop err_drop", errDrop, 1);
    checkOutput("drop err_order", errOrder, 0);
    checkOutput("drop sum held", resIf.out_sum, 30);
    checkOutput("drop pixel held", resIf.out_pixel, 6);
    checkOutput("drop valid held", resIf.out_valid, 1);
    outReady = 1'b1;
    tick();
    pushExp(1, 1'b0);
    pair(1, 2);
    pushExp(-2, 1'b0);
    pair(3, 1);
    pulseErrClr();
    checkOutput("err_clr err_drop", errDrop, 0);

    // Pixels 9..15 then wrap to 0.
    for (int i = 0; i < 8; i++) begin
      pushExp(3, 1'b0);
      pair(i, i + 3);
    end
    tick();

    // Order errors.
    strobe(2, 50);
    checkOutput("phi2 in IDLE err_order", errOrder, 1);
    checkOutput("phi2 in IDLE valid", resIf.out_valid, 0);
    pulseErrClr();
    checkOutput("err_clr err_order", errOrder, 0);
    tick();
    adcData = 12'd5; phi1 = 1'b1; phi2 = 1'b1;
    tick();
    phi1 = 1'b0; phi2 = 1'b0;
    checkOutput("simultaneous err_order", errOrder, 1);
    checkOutput("simultaneous valid", resIf.out_valid, 0);
    pulseErrClr();
    pushExp(5, 1'b0);
    pair(20, 25);
    checkOutput("after simultaneous err_order", errOrder, 0);
    tick();
    phi2 = 1'b1; errClr = 1'b1;
    tick();
    phi2 = 1'b0; errClr = 1'b0;
    checkOutput("set wins over clr", errOrder, 1);
    pulseErrClr();
    pushExp(30, 1'b0);
    strobe(1, 50);
    strobe(1, 70);
    strobe(2, 100);
    checkOutput("baseline replaced err_order", errOrder, 1);
    pulseErrClr();

    // skip_samples changed mid-pixel has no effect.
    skipSamples = 16'd2;
    pushExp(10, 1'b0);
    strobe(1, 0);
    skipSamples = 16'd1;
    strobe(2, 5);
    pair(0, 5);

    // Saturation on the 13-bit copy; the 32-bit DUT holds the full sum.
    skipSamples = 16'd3;
    pushExp(12285, 1'b0);
    pair(0, 4095);
    pair(0, 4095);
    pair(0, 4095);
    checkOutput("sat dut valid", satIf.out_valid, 1);
    checkOutput("sat dut sum", satIf.out_sum, 4095);
    checkOutput("sat dut out_sat", satIf.out_sat, 1);
    tick();

    // Cluster restart while a result is pending.
    skipSamples = 16'd1;
    outReady = 1'b0;
    heldPixel = expPixel;
    pushExp(8, 1'b0);
    pair(2, 10);
    riseIntegration();
    checkOutput("integ in OUT pixel held", resIf.out_pixel, heldPixel);
    checkOutput("integ in OUT valid held", resIf.out_valid, 1);
    outReady = 1'b1;
    tick();
    expPixel = 4'd0;
    pushExp(4, 1'b0);
    pair(2, 6);

    // Cluster restart during WAIT_BASE of pixel 5.
    riseIntegration();
    expPixel = 4'd0;
    for (int i = 0; i < 5; i++) begin
      pushExp(1, 1'b0);
      pair(i, i + 1);
    end
    skipSamples = 16'd2;
    pair(10, 20);
    riseIntegration();
    checkOutput("integ abort valid", resIf.out_valid, 0);
    expPixel = 4'd0;
    skipSamples = 16'd1;
    pushExp(3, 1'b0);
    pair(1, 4);
    tick();

    // Reset during OUT drops the result immediately.
    outReady = 1'b0;
    pair(7, 9);
    checkOutput("pre-reset valid", resIf.out_valid, 1);
    tick();
    reset = 1'b1;
    #1;
    checkOutput("async reset valid", resIf.out_valid, 0);
    checkOutput("async reset sum", resIf.out_sum, 0);
    checkOutput("async reset pixel", resIf.out_pixel, 0);
    tick();
    reset = 1'b0;
    outReady = 1'b1;
    expPixel = 4'd0;
    pushExp(2, 1'b0);
    pair(7, 9);
    tick();
    tick();
    tick();
    checkOutput("pending expectations", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
